// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// opcode / ext sub-op constants, PSR flag positions, condition codes and
// datapath mux selector values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_RTYPE, S_ITYPE, S_WB, S_MEMADR, S_LOAD,
    S_LDWB, S_STORE, S_BRANCH, S_JCOND, S_JAL, S_FAULT
  } state_t;

  // opCode1 classes
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_EXT   = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;

  // opCode2 sub-ops under OP_EXT, and the compare ALU function
  localparam logic [3:0] SUB_LOAD  = 4'h0;
  localparam logic [3:0] SUB_STOR  = 4'h4;
  localparam logic [3:0] SUB_JAL   = 4'h8;
  localparam logic [3:0] SUB_JCOND = 4'hC;
  localparam logic [3:0] FN_CMP    = 4'hB;
  localparam logic [3:0] ALU_ADD   = 4'h5;

  // PSR flag bit positions
  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  // condition codes
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
                         CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7,
                         CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB,
                         CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE;

  // mux selectors
  localparam logic [1:0] PC_INC  = 2'd0, PC_DISP = 2'd1, PC_REG  = 2'd2;
  localparam logic [1:0] WB_ALU  = 2'd0, WB_MEM  = 2'd1, WB_LINK = 2'd2;

  function automatic logic is_itype(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hE: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  // logical immediates are zero-extended, arithmetic ones sign-extended
  function automatic logic is_zext(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'hD: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational Bcond/Jcond evaluator.
//   cc   in  4  condition code field (instr[11:8])
//   psr  in  8  processor status register (C=0, L=2, F=5, Z=6, N=7)
//   cond out 1  condition holds
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cc,
  input  logic [7:0] psr,
  output logic       cond
);

  logic c, l, f, z, n;
  assign c = psr[PSR_C];
  assign l = psr[PSR_L];
  assign f = psr[PSR_F];
  assign z = psr[PSR_Z];
  assign n = psr[PSR_N];

  // PSR bits 1, 3 and 4 take no part in any condition
  logic unused_psr;
  assign unused_psr = ^{psr[4:3], psr[1]};

  always_comb begin
    cond = 1'b0;
    case (cc)
      CC_EQ: cond = z;
      CC_NE: cond = !z;
      CC_CS: cond = c;
      CC_CC: cond = !c;
      CC_HI: cond = l;
      CC_LS: cond = !l;
      CC_GT: cond = n;
      CC_LE: cond = !n;
      CC_FS: cond = f;
      CC_FC: cond = !f;
      CC_LO: cond = !z && !l;
      CC_HS: cond = z || l;
      CC_LT: cond = !z && !n;
      CC_GE: cond = z || n;
      CC_UC: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit for a 16-bit CR16-style datapath. Sequences
// fetch/decode/execute/memory/writeback, handshakes memory via mem_ready with
// a stall timeout, evaluates branch conditions and latches a sticky fault.
//   clk, reset                       clock, async active-high reset
//   opCode1/opCode2/conditionCode    instruction fields from the IR
//   PSR                              status flags for Bcond/Jcond
//   mem_ready                        memory completes the access this cycle
//   mem_req/mem_we/addr_sel          memory interface control
//   ir_en/pc_en/pc_src               IR load, PC update and PC source
//   src_b/zero_ext/alu_ctrl/psr_en   ALU operand, extension, function, flags
//   reg_we/wb_sel                    register writeback enable and source
//   fault                            sticky until reset
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int TIMEOUT = 15,
  parameter int TO_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opCode1,
  input  logic [3:0] opCode2,
  input  logic [3:0] conditionCode,
  input  logic [7:0] PSR,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_en,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       src_b,
  output logic       zero_ext,
  output logic [3:0] alu_ctrl,
  output logic       psr_en,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       fault
);

  if (TIMEOUT < 0 || TIMEOUT >= (1 << TO_BITS) || WIDTH < 1 || REGBITS < 1) begin : g_bad_param
    $error("multicycle_ctrl_fsm: illegal parameter combination");
  end

  // stall count at which the next stalled cycle reaches TIMEOUT
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t              state, state_next;
  logic [TO_BITS-1:0]  tcnt;
  logic                cond, wait_st, tmo;

  cond_eval u_cond (.cc(conditionCode), .psr(PSR), .cond(cond));

  assign wait_st = (state == S_FETCH) || (state == S_LOAD) || (state == S_STORE);
  // a ready on the final stalled cycle still completes the access
  assign tmo = (TIMEOUT != 0) && wait_st && !mem_ready && (tcnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // clears on every state change, so each FETCH/LOAD/STORE visit starts at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     tcnt <= '0;
    else if (state_next != state)  tcnt <= '0;
    else if (wait_st && !mem_ready) tcnt <= tcnt + 1'b1;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PC_INC;
    src_b      = 1'b0;
    zero_ext   = 1'b0;
    alu_ctrl   = ALU_ADD;
    psr_en     = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    fault      = 1'b0;
    // gating on reset makes an in-flight request drop asynchronously
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_en      = 1'b1;
            pc_en      = 1'b1;
            state_next = S_DECODE;
          end else if (tmo) state_next = S_FAULT;
        end
        S_DECODE: begin
          if (opCode1 == OP_RTYPE)      state_next = S_RTYPE;
          else if (is_itype(opCode1))   state_next = S_ITYPE;
          else if (opCode1 == OP_BCOND) state_next = S_BRANCH;
          else if (opCode1 == OP_EXT) begin
            case (opCode2)
              SUB_LOAD, SUB_STOR: state_next = S_MEMADR;
              SUB_JAL:            state_next = S_JAL;
              SUB_JCOND:          state_next = S_JCOND;
              default:            state_next = S_FAULT;
            endcase
          end else state_next = S_FAULT;
        end
        S_RTYPE: begin
          alu_ctrl   = opCode2;
          psr_en     = 1'b1;
          // CMP only sets flags, so it skips writeback
          state_next = (opCode2 == FN_CMP) ? S_FETCH : S_WB;
        end
        S_ITYPE: begin
          alu_ctrl   = opCode1;
          src_b      = 1'b1;
          psr_en     = 1'b1;
          zero_ext   = is_zext(opCode1);
          state_next = (opCode1 == OP_CMPI) ? S_FETCH : S_WB;
        end
        S_WB: begin
          reg_we     = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMADR: begin
          addr_sel   = 1'b1;
          state_next = (opCode2 == SUB_LOAD) ? S_LOAD : S_STORE;
        end
        S_LOAD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) state_next = S_LDWB;
          else if (tmo)  state_next = S_FAULT;
        end
        S_LDWB: begin
          reg_we     = 1'b1;
          wb_sel     = WB_MEM;
          state_next = S_FETCH;
        end
        S_STORE: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) state_next = S_FETCH;
          else if (tmo)  state_next = S_FAULT;
        end
        S_BRANCH: begin
          pc_en      = cond;
          pc_src     = PC_DISP;
          state_next = S_FETCH;
        end
        S_JCOND: begin
          pc_en      = cond;
          pc_src     = PC_REG;
          state_next = S_FETCH;
        end
        S_JAL: begin
          reg_we     = 1'b1;
          wb_sel     = WB_LINK;
          pc_en      = 1'b1;
          pc_src     = PC_REG;
          state_next = S_FETCH;
        end
        S_FAULT:  fault      = 1'b1;
        default:  state_next = S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: each instruction is expanded into the expected
// cycle-by-cycle output trace from the instruction-class rules, then
// replayed against the DUT with the per-cycle mem_ready of that trace.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [3:0] opCode1 = '0, opCode2 = '0, conditionCode = '0;
  logic [7:0] PSR = '0;
  logic       mem_req, mem_we, addr_sel, ir_en, pc_en, src_b, zero_ext;
  logic       psr_en, reg_we, fault;
  logic [1:0] pc_src, wb_sel;
  logic [3:0] alu_ctrl;

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opCode1(opCode1), .opCode2(opCode2),
    .conditionCode(conditionCode), .PSR(PSR), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_en(ir_en),
    .pc_en(pc_en), .pc_src(pc_src), .src_b(src_b), .zero_ext(zero_ext),
    .alu_ctrl(alu_ctrl), .psr_en(psr_en), .reg_we(reg_we), .wb_sel(wb_sel),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, ir_en, pc_en;
    logic [1:0] pc_src;
    logic       src_b, zero_ext;
    logic [3:0] alu_ctrl;
    logic       psr_en, reg_we;
    logic [1:0] wb_sel;
    logic       fault;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    rdy;
    string tag;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0, n_err = 0;
  localparam int TMO = 15;

  wire [17:0] got_v = {mem_req, mem_we, addr_sel, ir_en, pc_en, pc_src, src_b,
                       zero_ext, alu_ctrl, psr_en, reg_we, wb_sel, fault};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic outs_t idle();
    outs_t o = '0;
    o.alu_ctrl = 4'h5;
    return o;
  endfunction

  function automatic bit cond_ref(input logic [3:0] cc, input logic [7:0] p);
    bit z = p[6], c = p[0], l = p[2], f = p[5], n = p[7];
    bit [4:0] fl = {f, n, l, c, z};   // even codes test a flag, odd ones its complement
    if (cc < 4'hA) return fl[cc >> 1] ^ cc[0];
    case (cc)
      4'hA: return !z && !l;
      4'hB: return z || l;
      4'hC: return !z && !n;
      4'hD: return z || n;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input outs_t o, input bit r, input string t);
    ent_t e;
    e.o = o; e.rdy = r; e.tag = t;
    q.push_back(e);
  endtask

  // memory access of latency lat: stall cycles, then the completing cycle
  task automatic access(input outs_t base, input outs_t done, input int lat,
                        input string t, output bit to);
    to = (lat >= TMO);
    for (int i = 0; i < lat && i < TMO; i++) push(base, 1'b0, t);
    if (!to) push(done, 1'b1, t);
  endtask

  task automatic push_fault(input int n);
    outs_t o = idle();
    o.fault = 1'b1;
    for (int i = 0; i < n; i++) push(o, 1'($urandom), "fault");
  endtask

  // expected trace of one instruction; faulted=1 if it ends in FAULT
  task automatic model(input logic [3:0] op1, input logic [3:0] op2,
                       input logic [3:0] cc, input logic [7:0] p,
                       input int lat_f, input int lat_m, output bit faulted);
    outs_t b, d;
    bit to;
    faulted = 1'b0;
    b = idle(); b.mem_req = 1'b1;
    d = b; d.ir_en = 1'b1; d.pc_en = 1'b1;
    access(b, d, lat_f, "fetch", to);
    if (to) begin faulted = 1'b1; return; end
    push(idle(), 1'($urandom), "decode");
    b = idle();
    if (op1 == 4'h0) begin
      b.alu_ctrl = op2; b.psr_en = 1'b1;
      push(b, 1'($urandom), "rtype");
      if (op2 != 4'hB) begin d = idle(); d.reg_we = 1'b1; push(d, 1'($urandom), "wb"); end
    end else if (op1 inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hE}) begin
      b.alu_ctrl = op1; b.psr_en = 1'b1; b.src_b = 1'b1;
      b.zero_ext = (op1 inside {4'h1, 4'h2, 4'h3, 4'hD});
      push(b, 1'($urandom), "itype");
      if (op1 != 4'hB) begin d = idle(); d.reg_we = 1'b1; push(d, 1'($urandom), "wb"); end
    end else if (op1 == 4'hC) begin
      b.pc_en = cond_ref(cc, p); b.pc_src = 2'd1;
      push(b, 1'($urandom), "bcond");
    end else if (op1 == 4'h4 && (op2 == 4'h0 || op2 == 4'h4)) begin
      b.addr_sel = 1'b1;
      push(b, 1'($urandom), "memadr");
      b.mem_req = 1'b1; b.mem_we = (op2 == 4'h4);
      access(b, b, lat_m, (op2 == 4'h0) ? "load" : "store", to);
      if (to) begin faulted = 1'b1; return; end
      if (op2 == 4'h0) begin
        d = idle(); d.reg_we = 1'b1; d.wb_sel = 2'd1;
        push(d, 1'($urandom), "ldwb");
      end
    end else if (op1 == 4'h4 && op2 == 4'h8) begin
      b.reg_we = 1'b1; b.wb_sel = 2'd2; b.pc_en = 1'b1; b.pc_src = 2'd2;
      push(b, 1'($urandom), "jal");
    end else if (op1 == 4'h4 && op2 == 4'hC) begin
      b.pc_en = cond_ref(cc, p); b.pc_src = 2'd2;
      push(b, 1'($urandom), "jcond");
    end else faulted = 1'b1;
  endtask

  // replays up to n entries; starts and ends just after a negedge
  task automatic run_q(input int n);
    ent_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      mem_ready = e.rdy;
      #1;
      chk(e.tag, 32'(got_v), 32'(e.o));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    chk("reset", 32'(got_v), 32'(idle()));
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic instr(input logic [3:0] op1, input logic [3:0] op2,
                       input logic [3:0] cc, input logic [7:0] p,
                       input int lat_f, input int lat_m);
    bit flt;
    opCode1 = op1; opCode2 = op2; conditionCode = cc; PSR = p;
    model(op1, op2, cc, p, lat_f, lat_m, flt);
    if (flt) push_fault(3);
    run_q(q.size());
    if (flt) do_reset();
  endtask

  function automatic int rand_lat();
    if ($urandom_range(0, 39) == 0) return TMO + int'($urandom_range(0, 2));
    return int'($urandom_range(0, 4));
  endfunction

  initial begin
    logic [3:0] op1, op2;
    outs_t o;
    @(negedge clk);
    do_reset();
    // directed cases
    instr(4'h0, 4'h5, 4'h0, 8'h00, 0, 0);   // ADD R-type
    instr(4'h4, 4'h0, 4'h0, 8'h00, 0, 3);   // LOAD with 3 stalls
    instr(4'hC, 4'h0, 4'h0, 8'h40, 0, 0);   // Bcond EQ taken
    instr(4'hC, 4'h0, 4'h0, 8'h00, 0, 0);   // Bcond EQ not taken
    instr(4'h4, 4'h8, 4'h0, 8'h00, 0, 0);   // JAL
    instr(4'h0, 4'hB, 4'h0, 8'h00, 1, 0);   // CMP
    instr(4'hB, 4'h0, 4'h0, 8'h00, 0, 0);   // CMPI
    instr(4'h4, 4'h4, 4'h0, 8'h00, 0, 99);  // STORE never ready -> FAULT
    instr(4'h0, 4'h1, 4'h0, 8'h00, 14, 0);  // last fetch stall before timeout
    instr(4'h4, 4'h2, 4'h0, 8'h00, 0, 0);   // illegal ext sub-op
    // reset in the middle of a stalled LOAD
    opCode1 = 4'h4; opCode2 = 4'h0;
    begin bit f; model(4'h4, 4'h0, 4'h0, 8'h00, 0, 10, f); end
    run_q(5);
    mem_ready = 1'b0;
    #1;
    o = idle(); o.mem_req = 1'b1; o.addr_sel = 1'b1;
    chk("load_pre", 32'(got_v), 32'(o));
    #2 reset = 1'b1;
    #1 chk("arst_load", 32'(got_v), 32'(idle()));
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    instr(4'h5, 4'h0, 4'h0, 8'h00, 2, 0);   // resumes in FETCH
    // randomized instruction stream
    repeat (300) begin
      op1 = 4'($urandom);
      op2 = 4'($urandom);
      if (op1 == 4'h4 && $urandom_range(0, 3) != 0) op2 = {2'($urandom), 2'b00};
      instr(op1, op2, 4'($urandom), 8'($urandom), rand_lat(), rand_lat());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
